map_access_arbiter: RTL

Sequences and shares the single-port tile map between three requesters: the Pacman movement logic (port 0), the ghost AI (port 1) and the tile renderer (port 2). It sits directly in front of the map controller and drives its x/y/data_in/readwrite inputs. It serialises one read or write transaction at a time, returns read data with a one-cycle acknowledge, and rejects out-of-range coordinates without touching the map.

---
 rtl/map_access_arbiter.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/map_access_arbiter.sv
// ---------------------------------------------------------------------------
// map_access_arbiter
//
// Shares the single-port tile map between three requesters:
//   port 0 = Pacman movement, port 1 = ghost AI, port 2 = tile renderer.
// One read or write is carried at a time through IDLE -> ISSUE -> WAIT -> ACK.
// The winner's fields are latched in IDLE, so requesters may change them
// after the grant without affecting the transaction in flight.
// Out-of-range coordinates still walk the full sequence but never write the
// map, return rdata = 0 and raise oob with the ack pulse.
//
// Build option:
//   MAP_ARB_ROUND_ROBIN_EN  defined   -> round-robin arbitration; the search
//                                        starts at (last winner + 1) mod 3
//                           undefined -> fixed priority 0 > 1 > 2, no pointer
//
// Ports:
//   clock_50        in   1   system clock, rising edge
//   reset_n         in   1   synchronous active-low reset
//   req             in   3   request, bit i = requester i
//   req_we          in   3   write enable per requester (1 = write)
//   req_x, req_y    in  15   requester i coordinate at [5i+4:5i]
//   req_wdata       in   9   requester i tile code at [3i+2:3i]
//   ack             out  3   one-cycle one-hot completion pulse
//   rdata           out  3   read data, valid in the ack cycle only
//   oob             out  1   coordinates were out of range (with ack)
//   busy            out  1   FSM not in IDLE
//   map_x, map_y    out  5   coordinates to the map controller
//   map_data_in     out  3   write data to the map controller
//   map_readwrite   out  1   1 = write, high only in ISSUE
//   map_data_out    in   3   map read data, one cycle after the address
// ---------------------------------------------------------------------------
module map_access_arbiter #(
  parameter int MAP_COLS = 20,
  parameter int MAP_ROWS = 25
) (
  input  logic        clock_50,
  input  logic        reset_n,
  input  logic [2:0]  req,
  input  logic [2:0]  req_we,
  input  logic [14:0] req_x,
  input  logic [14:0] req_y,
  input  logic [8:0]  req_wdata,
  output logic [2:0]  ack,
  output logic [2:0]  rdata,
  output logic        oob,
  output logic        busy,
  output logic [4:0]  map_x,
  output logic [4:0]  map_y,
  output logic [2:0]  map_data_in,
  output logic        map_readwrite,
  input  logic [2:0]  map_data_out
);

  // Limits widened by one bit so a limit of 32 still compares correctly.
  localparam logic [5:0] LIM_X = 6'(MAP_COLS);
  localparam logic [5:0] LIM_Y = 6'(MAP_ROWS);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_ACK   = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic [1:0]  w_win;
  logic        w_grant;
  logic        w_sel_we;
  logic [4:0]  w_sel_x;
  logic [4:0]  w_sel_y;
  logic [2:0]  w_sel_wdata;
  logic        w_sel_oob;

  logic [1:0]  r_win;
  logic        r_we;
  logic [4:0]  r_x;
  logic [4:0]  r_y;
  logic [2:0]  r_wdata;
  logic        r_oob;

  logic [2:0]  r_ack;
  logic [2:0]  r_rdata;
  logic        r_oob_out;

`ifdef MAP_ARB_ROUND_ROBIN_EN
  logic [1:0]  r_last;

  // First requester found when searching upward from last + 1 (mod 3).
  function automatic logic [1:0] pick_rr(input logic [2:0] r,
                                         input logic [1:0] last);
    logic [1:0] c;
    logic       found;
    logic [1:0] res;
    c     = last;
    found = 1'b0;
    res   = 2'd0;
    for (int k = 0; k < 3; k++) begin
      c = (c == 2'd2) ? 2'd0 : c + 2'd1;
      if (!found && r[c]) begin
        res   = c;
        found = 1'b1;
      end
    end
    return res;
  endfunction
`else
  function automatic logic [1:0] pick_fixed(input logic [2:0] r);
    if (r[0])      return 2'd0;
    else if (r[1]) return 2'd1;
    else           return 2'd2;
  endfunction
`endif

  // Arbitration and field selection for the candidate winner.
  always_comb begin
`ifdef MAP_ARB_ROUND_ROBIN_EN
    w_win = pick_rr(req, r_last);
`else
    w_win = pick_fixed(req);
`endif
    w_grant     = |req;
    w_sel_we    = req_we[0];
    w_sel_x     = req_x[4:0];
    w_sel_y     = req_y[4:0];
    w_sel_wdata = req_wdata[2:0];
    case (w_win)
      2'd1: begin
        w_sel_we    = req_we[1];
        w_sel_x     = req_x[9:5];
        w_sel_y     = req_y[9:5];
        w_sel_wdata = req_wdata[5:3];
      end
      2'd2: begin
        w_sel_we    = req_we[2];
        w_sel_x     = req_x[14:10];
        w_sel_y     = req_y[14:10];
        w_sel_wdata = req_wdata[8:6];
      end
      default: ;
    endcase
    w_sel_oob = ({1'b0, w_sel_x} >= LIM_X) || ({1'b0, w_sel_y} >= LIM_Y);
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_grant) w_state_nxt = S_ISSUE;
      S_ISSUE: w_state_nxt = S_WAIT;
      S_WAIT:  w_state_nxt = S_ACK;
      S_ACK:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock_50) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Transaction latch: captured once per grant, held until the next grant.
  // map_x/map_y follow these registers, so they hold outside ISSUE.
  always_ff @(posedge clock_50) begin
    if (!reset_n) begin
      r_win   <= 2'd0;
      r_we    <= 1'b0;
      r_x     <= 5'd0;
      r_y     <= 5'd0;
      r_wdata <= 3'd0;
      r_oob   <= 1'b0;
    end else if (r_state == S_IDLE && w_grant) begin
      r_win   <= w_win;
      r_we    <= w_sel_we;
      r_x     <= w_sel_x;
      r_y     <= w_sel_y;
      r_wdata <= w_sel_wdata;
      r_oob   <= w_sel_oob;
    end
  end

`ifdef MAP_ARB_ROUND_ROBIN_EN
  // Reset value 2 makes requester 0 the first to be searched.
  always_ff @(posedge clock_50) begin
    if (!reset_n)                            r_last <= 2'd2;
    else if (r_state == S_IDLE && w_grant)   r_last <= w_win;
  end
`endif

  // Completion outputs: loaded at the edge ending WAIT so they are visible
  // for exactly the ACK cycle, cleared on every other edge.
  always_ff @(posedge clock_50) begin
    if (!reset_n) begin
      r_ack     <= 3'd0;
      r_rdata   <= 3'd0;
      r_oob_out <= 1'b0;
    end else begin
      r_ack     <= 3'd0;
      r_rdata   <= 3'd0;
      r_oob_out <= 1'b0;
      if (r_state == S_WAIT) begin
        r_ack     <= 3'(3'b001 << r_win);
        r_oob_out <= r_oob;
        if (!r_we && !r_oob) r_rdata <= map_data_out;
      end
    end
  end

  assign ack         = r_ack;
  assign rdata       = r_rdata;
  assign oob         = r_oob_out;
  assign busy        = (r_state != S_IDLE);
  assign map_x       = r_x;
  assign map_y       = r_y;
  assign map_data_in = r_wdata;

  // Gated by reset_n so a reset asserted during ISSUE keeps the map from
  // committing the interrupted write on that same edge.
  assign map_readwrite = (r_state == S_ISSUE) && r_we && !r_oob && reset_n;

endmodule
